// File: rtl/serializer_feeder.sv
// serializer_feeder
// Byte FIFO in front of an external 8-bit parallel-load serializer. Bytes
// written on wr_data are queued, then handed one at a time to the serializer
// through a LOAD/SHIFT handshake. A watchdog limits how long SHIFT waits for
// ser_done. Each completed byte is counted in tx_count.
//
// Optional feature: define TX_GAP_EN to compile in the GAP state. GAP keeps the
// serializer in reset for GAP_CYCLES cycles between bytes.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   wr_data      byte to queue
//   wr_en        write strobe, one byte per cycle
//   full, empty  FIFO status
//   overflow     sticky, a write was attempted while full
//   ser_data     byte presented to the serializer, stable during SHIFT
//   ser_start    serializer start
//   ser_reset    serializer reset, active-high
//   ser_done     serializer done_transmit, only looked at in SHIFT
//   busy         FSM is not in IDLE
//   timeout_err  sticky, ser_done did not arrive within TIMEOUT_CYCLES
//   tx_count     bytes completed, wraps at 16 bits
module serializer_feeder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [7:0]  ser_data,
  output logic        ser_start,
  output logic        ser_reset,
  input  logic        ser_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] tx_count
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One counter serves both the SHIFT watchdog and the GAP delay, so it is
  // sized for whichever limit is larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
`ifdef TX_GAP_EN
    ,
    GAP   = 2'd3
`endif
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  logic            shift_done;
  logic            shift_timeout;
  logic            cnt_run;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  // A write while full is dropped even if a pop frees a slot in that same cycle.
  assign push  = wr_en && !full;
  assign pop   = (state == LOAD) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ser_data <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        ser_data <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Next state and Moore outputs. cnt_run keeps the shared counter running
  // while SHIFT or GAP is held. Any state change restarts the counter from
  // zero.
  always_comb begin
    state_next    = state;
    shift_done    = 1'b0;
    shift_timeout = 1'b0;
    cnt_run       = 1'b0;
    ser_start     = 1'b0;
    ser_reset     = 1'b1;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!empty) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        ser_start  = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        ser_start = 1'b1;
        ser_reset = 1'b0;
        if (ser_done) begin
          shift_done = 1'b1;
`ifdef TX_GAP_EN
          state_next = GAP;
`else
          state_next = empty ? IDLE : LOAD;
`endif
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          shift_timeout = 1'b1;
          state_next    = IDLE;
        end else begin
          cnt_run = 1'b1;
        end
      end
`ifdef TX_GAP_EN
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_next = empty ? IDLE : LOAD;
        end else begin
          cnt_run = 1'b1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_count    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_run ? cnt + CW'(1) : '0;
      if (shift_done) begin
        tx_count <= tx_count + 16'd1;
      end
      if (shift_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serializer_feeder.sv
// tb_serializer_feeder
// Self-checking bench for serializer_feeder. A behavioural serializer drives
// ser_done and rebuilds bytes from the LSB-first serial stream. The bench
// compares those bytes with a queue of the bytes it wrote that should be
// delivered. Define TX_GAP_EN on both files to check the inter-byte gap.
module tb_serializer_feeder;

  localparam int FIFO_DEPTH     = 8;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int GAP_CYCLES     = 4;
`ifdef TX_GAP_EN
  localparam int EXP_GAP = GAP_CYCLES;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  ser_data;
  logic        ser_start;
  logic        ser_reset;
  logic        ser_done;
  logic        busy;
  logic        timeout_err;
  logic [15:0] tx_count;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         tx_exp = 0;
  int         start_count = 0;
  bit         stall = 1'b0;
  int         ser_cnt = 0;
  logic [7:0] shreg = 8'd0;
  logic       line_bit;
  bit         gap_armed = 1'b0;
  int         gap_run = 0;
  int         last_gap = -1;

  serializer_feeder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .ser_data(ser_data),
    .ser_start(ser_start),
    .ser_reset(ser_reset),
    .ser_done(ser_done),
    .busy(busy),
    .timeout_err(timeout_err),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // Serializer model. While held in reset it is cleared. Once started, it
  // emits one bit per cycle, LSB first, unless stalled. After 8 bits it
  // raises done. The receiver shifts each bit in from the MSB side. The
  // number of start=0 cycles between done and the next LOAD is recorded.
  initial begin
    ser_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_start && ser_reset) start_count++;
      if (gap_armed) begin
        if (!ser_start) gap_run++;
        else begin
          last_gap  = gap_run;
          gap_armed = 1'b0;
        end
      end
      if (!reset || ser_reset) begin
        ser_cnt  = 0;
        ser_done = 1'b0;
      end else if (ser_start && !stall && ser_cnt < 8) begin
        line_bit = ser_data[ser_cnt];
        shreg    = {line_bit, shreg[7:1]};
        ser_cnt++;
        if (ser_cnt == 8) begin
          rx_q.push_back(shreg);
          ser_done  = 1'b1;
          gap_armed = 1'b1;
          gap_run   = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One write cycle, entered and left on a falling edge.
  task automatic applyStimulus(input logic [7:0] data, input bit accepted);
    wr_en   = 1'b1;
    wr_data = data;
    if (accepted) exp_q.push_back(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || !empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busy || !empty), 32'd0);
  endtask

  task automatic waitShift(input int budget);
    int n = 0;
    while (!(ser_start && !ser_reset) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("shift_reached", 32'(ser_start && !ser_reset), 32'd1);
  endtask

  task automatic waitLoad(input int budget);
    int n = 0;
    while (!(ser_start && ser_reset) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("load_reached", 32'(ser_start && ser_reset), 32'd1);
  endtask

  task automatic compareStream(input string tag);
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    checkOutput({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) checkOutput({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    tx_exp += exp_q.size();
    checkOutput({tag, "_tx_count"}, 32'(tx_count), 32'(16'(tx_exp)));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    checkOutput({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    checkOutput({tag, "_ser_data"}, 32'(ser_data), 32'd0);
    checkOutput({tag, "_ser_start"}, 32'(ser_start), 32'd0);
    checkOutput({tag, "_ser_reset"}, 32'(ser_reset), 32'd1);
  endtask

  initial begin
    int shift_cycles;
    int n;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'd0;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    reset = 1'b1;
    @(negedge clk);

    // Two bytes back to back
    applyStimulus(8'h2D, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    waitIdle(300);
    compareStream("b2b");
    checkOutput("b2b_gap", 32'(last_gap), 32'(EXP_GAP));

    // Simultaneous write and pop at occupancy 3
    stall = 1'b1;
    applyStimulus(8'h01, 1'b1);
    waitShift(20);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    stall = 1'b0;
    waitLoad(40);
    wr_en   = 1'b1;
    wr_data = 8'h44;
    exp_q.push_back(8'h44);
    stall = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("occ3_empty", 32'(empty), 32'd0);
    checkOutput("occ3_full", 32'(full), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'hC0 + 8'(i), 1'b1);
      if (i == 3) checkOutput("occ7_full", 32'(full), 32'd0);
      if (i == 4) checkOutput("occ8_full", 32'(full), 32'd1);
    end
    checkOutput("occ_overflow", 32'(overflow), 32'd0);
    stall = 1'b0;
    waitIdle(400);
    compareStream("occ");

    // Overflow with the serializer stalled
    stall = 1'b1;
    applyStimulus(8'h5A, 1'b1);
    waitShift(20);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      applyStimulus(8'h80 + 8'(i), i < FIFO_DEPTH);
      if (i == FIFO_DEPTH - 2) checkOutput("ovf_not_full", 32'(full), 32'd0);
      if (i == FIFO_DEPTH - 1) begin
        checkOutput("ovf_full", 32'(full), 32'd1);
        checkOutput("ovf_clear", 32'(overflow), 32'd0);
      end
    end
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_still_full", 32'(full), 32'd1);
    stall = 1'b0;
    waitIdle(400);
    compareStream("ovf");
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Timeout: serializer never finishes
    stall = 1'b1;
    applyStimulus(8'h3C, 1'b0);
    waitShift(20);
    shift_cycles = 1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      if (ser_start && !ser_reset) shift_cycles++;
    end
    checkOutput("tmo_shift_cycles", 32'(shift_cycles), 32'(TIMEOUT_CYCLES));
    checkOutput("tmo_err", 32'(timeout_err), 32'd1);
    checkOutput("tmo_busy", 32'(busy), 32'd0);
    checkOutput("tmo_tx_count", 32'(tx_count), 32'(16'(tx_exp)));
    checkOutput("tmo_rx_len", 32'(rx_q.size()), 32'd0);
    stall = 1'b0;

    // Reset mid-SHIFT with three bytes queued
    stall = 1'b1;
    applyStimulus(8'h77, 1'b0);
    waitShift(20);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h56, 1'b0);
    reset = 1'b0;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    rx_q.delete();
    exp_q.delete();
    tx_exp      = 0;
    start_count = 0;
    repeat (40) @(negedge clk);
    checkOutput("midrst_no_start", 32'(start_count), 32'd0);
    checkOutput("midrst_empty_after", 32'(empty), 32'd1);
    checkOutput("midrst_busy_after", 32'(busy), 32'd0);

    // Randomized bursts that never exceed the FIFO depth
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < n; i++) begin
        applyStimulus(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      waitIdle(500);
      compareStream("rand");
    end
    checkOutput("rand_overflow", 32'(overflow), 32'd0);
    checkOutput("rand_timeout_err", 32'(timeout_err), 32'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/serializer_feeder.md
SERIALIZER_FEEDER -- requirements
Module: serializer_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO depth (power of 2, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32, max cycles SHIFT may wait for ser_done.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles between bytes (used only when TX_GAP_EN defined).
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_data  input  8  byte to queue.
- wr_en  input  1  write strobe, one byte per cycle.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- overflow  output  1  sticky, write attempted while full.
- ser_data  output  8  drives serializer data_in.
- ser_start  output  1  drives serializer start.
- ser_reset  output  1  drives serializer reset, active-high.
- ser_done  input  1  serializer done_transmit.
- busy  output  1  high in any state except IDLE.
- timeout_err  output  1  sticky, ser_done not seen in time.
- tx_count  output  16  bytes completed, wraps at 65535->0.

Function
REQ-005 SHALL be one clock domain; all state SHALL be registered on rising clk.
REQ-006 FIFO SHALL accept wr_data when wr_en=1 and full=0; when full=1 the write SHALL be dropped and overflow set, even if a pop occurs in the same cycle.
REQ-007 A simultaneous write and pop with FIFO neither full nor empty SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-008 FSM states SHALL be IDLE, LOAD, SHIFT, GAP.
REQ-009 IDLE: ser_start=0, ser_reset=1; if empty=0 go to LOAD next cycle, else stay.
REQ-010 LOAD (exactly 1 cycle): pop the FIFO head into ser_data; ser_start=1, ser_reset=1 (clears serializer); go to SHIFT.
REQ-011 SHIFT: ser_start=1, ser_reset=0; ser_data SHALL stay stable; the timeout counter SHALL increment each cycle.
REQ-012 SHIFT, ser_done=1: increment tx_count; go to GAP if TX_GAP_EN is defined, else go to LOAD if empty=0, else IDLE.
REQ-013 SHIFT, counter reaches TIMEOUT_CYCLES without ser_done: set timeout_err, do not increment tx_count, go to IDLE; the byte is discarded.
REQ-014 GAP: ser_start=0, ser_reset=1 for GAP_CYCLES cycles; then go to LOAD if empty=0, else IDLE.
REQ-015 ser_done SHALL be ignored outside SHIFT.
REQ-016 Back-to-back bytes without TX_GAP_EN: the ser_done cycle SHALL be followed directly by LOAD, giving continuous 8-bit frames separated by the serializer's own reset and done latency only.
REQ-017 overflow and timeout_err SHALL clear only on reset.

Reset
REQ-018 reset=0 SHALL asynchronously force: FSM=IDLE, FIFO empty (pointers 0), full=0, empty=1, overflow=0, timeout_err=0, tx_count=0, ser_data=0, ser_start=0, ser_reset=1, busy=0, timeout counter 0.
REQ-019 Reset asserted mid-SHIFT SHALL abort the byte and discard all queued bytes; release SHALL resume in IDLE on the next rising clk.

Configuration
REQ-020 Macro TX_GAP_EN: when defined, the GAP state and GAP_CYCLES SHALL be compiled in; when undefined, GAP SHALL be absent and SHIFT SHALL exit directly per REQ-012.

Verification
REQ-021 Reset, write 8'h2D, 8'hA5 back-to-back, model serializer: serial line carries LSB-first 2D then A5; tx_count=2; empty=1; busy falls after the last ser_done.
REQ-022 Write FIFO_DEPTH+1 bytes with the serializer stalled (ser_done=0): full=1 after FIFO_DEPTH writes; 9th byte dropped; overflow=1.
REQ-023 Hold ser_done=0 for the whole SHIFT: timeout_err=1 after 32 SHIFT cycles; tx_count unchanged; FSM in IDLE.
REQ-024 Assert reset for 1 cycle mid-SHIFT with 3 bytes queued: all outputs take REQ-018 values asynchronously; empty=1; no further ser_start.
REQ-025 TX_GAP_EN defined, GAP_CYCLES=4, two bytes queued: exactly 4 cycles with ser_start=0 between ser_done and the next LOAD.
REQ-026 Write and pop in the same cycle at occupancy 3: occupancy stays 3; byte order preserved.
